// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU for the 24-bit CPU.
//
// Single-cycle ops (AND/OR/ADD/SUB/SLT/XOR/SLL) register their result on the
// accept edge. MUL is an iterative shift-add multiplier: one partial product per
// cycle, WIDTH cycles by default. Valid/ready handshakes on both sides let the
// control FSM stall while a MUL is in flight.
//
// Optional feature macro: MUL_EARLY_TERM_EN
//   When defined, MUL finishes as soon as no set multiplier bits remain.
//   The result is identical either way; only the latency changes.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands and alu_ctrl valid this cycle
//   in_ready   unit can accept an operation
//   alu_ctrl   4-bit ALUCtrl code (see Op* localparams)
//   op_a       operand A (rs)
//   op_b       operand B (rt/imm)
//   out_valid  result/flags valid, held until out_ready
//   out_ready  consumer takes the result
//   result     operation result
//   zero       result == 0
//   illegal    alu_ctrl was not a recognised code
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b1010;
    localparam logic [3:0] OpSlt = 4'b1011;
    localparam logic [3:0] OpXor = 4'b0101;
    localparam logic [3:0] OpSll = 4'b0110;
    localparam logic [3:0] OpMul = 4'b0100;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   acc_nxt;
    logic               mul_last;

    assign shamt = op_b[SHAMT_W-1:0];

    // Single-cycle result, consumed only on the accept edge.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (alu_ctrl)
            OpAnd: alu_res = op_a & op_b;
            OpOr:  alu_res = op_a | op_b;
            OpAdd: alu_res = op_a + op_b;
            OpSub: alu_res = op_a - op_b;
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OpXor: alu_res = op_a ^ op_b;
            OpSll: alu_res = (32'(shamt) >= WIDTH) ? '0 : (op_a << shamt);
            OpMul: alu_res = '0;
            default: begin
                alu_res = '0;
                alu_ill = 1'b1;
            end
        endcase
    end

    // One shift-add step per MUL cycle.
    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_EARLY_TERM_EN
    // Stop once the bit being consumed now is the last set one.
    assign mul_last = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == CntW'(WIDTH-1));
`else
    assign mul_last = (cnt_q == CntW'(WIDTH-1));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (alu_ctrl == OpMul) begin
                            mcand_q  <= op_a;
                            mplier_q <= op_b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= StMul;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            illegal_q   <= alu_ill;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StMul: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    acc_q    <= acc_nxt;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (mul_last) begin
                        result_q    <= acc_nxt;
                        zero_q      <= (acc_nxt == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit.
// Honours MUL_EARLY_TERM_EN for the expected MUL latencies.
module tb_alu_exec_unit;

    localparam int unsigned WIDTH = 24;

`ifdef MUL_EARLY_TERM_EN
    localparam int MulLat100  = 8;   // op_b=100, highest set bit 6
    localparam int MulLatFull = 25;  // op_b bit 23 set
    localparam int MulLatZero = 2;   // op_b=0
`else
    localparam int MulLat100  = 25;
    localparam int MulLatFull = 25;
    localparam int MulLatZero = 25;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the operands after the accept edge, measure latency
    // in clock edges from the accept edge, check outputs, then pop the result.
    task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [23:0] a,
                          input logic [23:0] b, input logic [23:0] exp_res, input int exp_lat,
                          input logic exp_ill);
        int n;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        alu_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        alu_ctrl = 4'b0010;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, {8'd0, result}, {8'd0, exp_res});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 24'd0)});
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_pop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;

        // Reset state
        #22 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {8'd0, result}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);

        // Single-cycle ops
        run_op("add_wrap", 4'b0010, 24'hFFFFFF, 24'h000001, 24'h000000, 1, 1'b0);
        run_op("sub_neg",  4'b1010, 24'd5,      24'd7,      24'hFFFFFE, 1, 1'b0);
        run_op("slt_neg",  4'b1011, 24'h800000, 24'h000001, 24'h000001, 1, 1'b0);
        run_op("slt_pos",  4'b1011, 24'h000001, 24'h800000, 24'h000000, 1, 1'b0);
        run_op("and",      4'b0000, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, 1, 1'b0);
        run_op("or",       4'b0001, 24'h123400, 24'h00ABCD, 24'h12BFCD, 1, 1'b0);
        run_op("xor",      4'b0101, 24'hA5A5A5, 24'hFFFF00, 24'h5A5AA5, 1, 1'b0);
        run_op("sll4",     4'b0110, 24'd3,      24'd4,      24'h000030, 1, 1'b0);
        run_op("sll23",    4'b0110, 24'd1,      24'd23,     24'h800000, 1, 1'b0);
        run_op("sll24",    4'b0110, 24'd3,      24'd24,     24'h000000, 1, 1'b0);
        run_op("illegal",  4'b1111, 24'h123456, 24'h654321, 24'h000000, 1, 1'b1);

        // Multiplies
        run_op("mul_1234", 4'b0100, 24'd1234,   24'd100,    24'd123400, MulLat100, 1'b0);
        run_op("mul_m1",   4'b0100, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, MulLatFull, 1'b0);
        run_op("mul_zero", 4'b0100, 24'd7,      24'd0,      24'h000000, MulLatZero, 1'b0);

        // Backpressure: result held stable while out_ready stays low
        alu_ctrl = 4'b0010;
        op_a     = 24'd10;
        op_b     = 24'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_result", {8'd0, result}, 32'd30);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset mid-MUL aborts the operation
        alu_ctrl = 4'b0100;
        op_a     = 24'd5;
        op_b     = 24'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mul_busy", {31'd0, in_ready}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_result", {8'd0, result}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_output", {31'd0, out_valid}, 32'd0);
        run_op("post_rst_add", 4'b0010, 24'd2, 24'd3, 24'd5, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
